// File: rtl/rename_pkg.sv
// Shared types and constants for the rename stage and its free list.
package rename_pkg;

  localparam int NAREG  = 32;
  localparam int NPREG  = 64;
  localparam int AREG_W = $clog2(NAREG);
  localparam int PREG_W = $clog2(NPREG);

  typedef logic [AREG_W-1:0] t_areg;
  typedef logic [PREG_W-1:0] t_preg;

  // Free-list contents right after reset: every preg above the architectural range.
  localparam logic [NPREG-1:0] FREE_RESET = {{(NPREG-NAREG){1'b1}}, {NAREG{1'b0}}};

  typedef enum logic [1:0] {
    OP_INVD = 2'd0,
    OP_REG  = 2'd1,
    OP_IMM  = 2'd2,
    OP_MEM  = 2'd3
  } t_optype;

  typedef struct packed {
    t_optype optype;
    t_areg   opreg;
  } t_opnd;

  typedef struct packed {
    logic [7:0]  uop;
    t_opnd       dst;
    t_opnd       src1;
    t_opnd       src2;
    logic [15:0] imm;
  } t_uinstr;

  typedef struct packed {
    t_uinstr uinstr;
    t_preg   psrc1;
    t_preg   psrc2;
    t_preg   pdst;
    t_preg   pdst_old;
  } t_uinstr_rn;

  typedef struct packed {
    logic  dst_vld;
    t_areg areg;
    t_preg pdst;
    t_preg pdst_old;
  } t_rename_retire_pkt;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } t_nuke_pkt;

  // Lowest set bit of a preg vector; returns 0 for an empty vector.
  function automatic t_preg ffs(input logic [NPREG-1:0] v);
    t_preg r;
    r = '0;
    for (int i = NPREG - 1; i >= 0; i--) begin
      if (v[i]) r = t_preg'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rename_if.sv
// Decode -> rename -> allocation handshake bundle.
// Handshake: decode raises valid_de1 only in a cycle where rename_ready_rn0
// is 1, so valid_de1 alone means transfer. valid_rn1 is a single-cycle pulse
// per uop with no back-pressure, because alloc_ready_ra0 was already folded
// into rename_ready_rn0 the cycle before.
interface rename_if;
  import rename_pkg::*;

  logic       valid_de1;
  t_uinstr    uinstr_de1;
  logic       rename_ready_rn0;
  logic       alloc_ready_ra0;
  logic       valid_rn1;
  t_uinstr_rn uinstr_rn1;

  // Upstream decode plus downstream allocation side.
  modport master (
    output valid_de1, uinstr_de1, alloc_ready_ra0,
    input  rename_ready_rn0, valid_rn1, uinstr_rn1
  );

  // Rename stage side.
  modport slave (
    input  valid_de1, uinstr_de1, alloc_ready_ra0,
    output rename_ready_rn0, valid_rn1, uinstr_rn1
  );
endinterface

// File: rtl/rename_free_list.sv
// Bit-vector physical register free list with retirement-used shadow vector.
module rn_free_list
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  alloc_req_i,
  output t_preg alloc_preg_o,
  output logic  avail_o,
  input  logic  free_req_i,
  input  t_preg free_preg_i,
  input  logic  used_upd_i,
  input  t_preg used_set_i,
  input  t_preg used_clr_i,
  input  logic  nuke_i
);

  logic [NPREG-1:0] free_q, free_d;
  logic [NPREG-1:0] used_q, used_d;

  // Selection always works on the pre-update vector, so a preg freed this
  // cycle is never handed out in the same cycle.
  assign alloc_preg_o = ffs(free_q);
  assign avail_o      = |free_q;

  // Next-state of both vectors from this cycle's allocate/free/retire events.
  always_comb begin
    free_d = free_q;
    used_d = used_q;
    if (alloc_req_i) free_d[alloc_preg_o] = 1'b0;
    if (free_req_i)  free_d[free_preg_i]  = 1'b1;
    if (used_upd_i) begin
      used_d[used_set_i] = 1'b1;
      used_d[used_clr_i] = 1'b0;
    end
  end

  // State update; a nuke rebuilds the free list from the retired mapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_q <= FREE_RESET;
      used_q <= ~FREE_RESET;
    end else if (nuke_i) begin
      used_q <= used_d;
      free_q <= ~used_d;
    end else begin
      free_q <= free_d;
      used_q <= used_d;
    end
  end

  // Allocating from an empty list or double-freeing a preg is a pipeline bug.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc_req_i) assert (avail_o);
      if (free_req_i)  assert (!free_q[free_preg_i]);
    end
  end

endmodule

// File: rtl/rename.sv
// Rename stage: speculative RAT lookup/update, RRAT tracking, 1-cycle output pipe.
module rename
  import rename_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  t_nuke_pkt          nuke_rb1,
  input  logic               retire_valid_rb1,
  input  t_rename_retire_pkt retire_pkt_rb1,
  rename_if.slave            rn_if
);

  t_preg      rat_q  [NAREG];
  t_preg      rrat_q [NAREG];
  t_preg      rrat_d [NAREG];

  logic       valid_rn1_q;
  t_uinstr_rn uinstr_rn1_q;
  t_uinstr_rn uop_rn0;

  logic       fire_rn0;
  logic       dst_is_reg;
  logic       alloc_req;
  t_preg      alloc_preg;
  logic       avail;
  logic       retire_dst;
  logic       unused_nuke_pc;

  assign unused_nuke_pc = ^nuke_rb1.pc;

  assign retire_dst = retire_valid_rb1 & retire_pkt_rb1.dst_vld;

  // Conservative: one free preg is required even for uops without a destination.
  assign rn_if.rename_ready_rn0 = rn_if.alloc_ready_ra0 & avail & ~nuke_rb1.valid & ~reset;

  assign fire_rn0   = rn_if.valid_de1;
  assign dst_is_reg = (rn_if.uinstr_de1.dst.optype == OP_REG);
  assign alloc_req  = fire_rn0 & dst_is_reg;

  rn_free_list u_free_list (
    .clk          (clk),
    .reset        (reset),
    .alloc_req_i  (alloc_req),
    .alloc_preg_o (alloc_preg),
    .avail_o      (avail),
    .free_req_i   (retire_dst),
    .free_preg_i  (retire_pkt_rb1.pdst_old),
    .used_upd_i   (retire_dst),
    .used_set_i   (retire_pkt_rb1.pdst),
    .used_clr_i   (retire_pkt_rb1.pdst_old),
    .nuke_i       (nuke_rb1.valid)
  );

  // Build the renamed uop from the current RAT; no bypass since writes land at the edge.
  always_comb begin
    uop_rn0          = '0;
    uop_rn0.uinstr   = rn_if.uinstr_de1;
    if (rn_if.uinstr_de1.src1.optype == OP_REG)
      uop_rn0.psrc1 = rat_q[rn_if.uinstr_de1.src1.opreg];
    if (rn_if.uinstr_de1.src2.optype == OP_REG)
      uop_rn0.psrc2 = rat_q[rn_if.uinstr_de1.src2.opreg];
    if (dst_is_reg) begin
      uop_rn0.pdst     = alloc_preg;
      uop_rn0.pdst_old = rat_q[rn_if.uinstr_de1.dst.opreg];
    end
  end

  // Retirement mapping including this cycle's retire, used both normally and on nuke.
  always_comb begin
    rrat_d = rrat_q;
    if (retire_dst) rrat_d[retire_pkt_rb1.areg] = retire_pkt_rb1.pdst;
  end

  // RAT/RRAT update and output pipe register; nuke restores RAT from the retired view.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NAREG; i++) begin
        rat_q[i]  <= t_preg'(i);
        rrat_q[i] <= t_preg'(i);
      end
      valid_rn1_q  <= 1'b0;
      uinstr_rn1_q <= '0;
    end else if (nuke_rb1.valid) begin
      rat_q       <= rrat_d;
      rrat_q      <= rrat_d;
      valid_rn1_q <= 1'b0;
    end else begin
      rrat_q      <= rrat_d;
      valid_rn1_q <= fire_rn0;
      if (alloc_req) rat_q[rn_if.uinstr_de1.dst.opreg] <= alloc_preg;
      if (fire_rn0)  uinstr_rn1_q <= uop_rn0;
    end
  end

  // Decode must never present a uop that rename has not declared ready for.
  always_ff @(posedge clk) begin
    if (!reset) assert (!rn_if.valid_de1 || rn_if.rename_ready_rn0);
  end

  assign rn_if.valid_rn1  = valid_rn1_q;
  assign rn_if.uinstr_rn1 = uinstr_rn1_q;

endmodule
